// File: rtl/mm_pkg.sv
// Shared constants and types for the 5x5 systolic multiplier sequencer.
// Holds the default geometry, the sequencer state encoding and the counter width.
// No logic here; imported by mm_buf and mm_sched.
package mm_pkg;

  localparam int MM_N         = 5;
  localparam int MM_DW        = 8;
  localparam int MM_DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    CAPT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  // The shared FEED/DRAIN counter must reach 3N-3 (last feed wavefront).
  function automatic int cnt_width(input int n);
    return $clog2(3 * n - 1);
  endfunction

  localparam int MM_CNT_W = cnt_width(MM_N);

endpackage

// File: rtl/mm_buf.sv
// N x N operand register file: synchronous single-element write, full combinational read.
// Latency: write visible one cycle after the strobe; read is zero-latency.
// No backpressure; the caller gates we_i (range check and idle-only policy live upstream).
module mm_buf
  import mm_pkg::*;
#(
  parameter int N  = MM_N,
  parameter int DW = MM_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] row_i,
  input  logic [$clog2(N)-1:0] col_i,
  input  logic [DW-1:0]        data_i,
  output logic [N*N*DW-1:0]    mem_o
);

  // Element (r,c) lives at bits (r*N+c)*DW +: DW.
  logic [N*N*DW-1:0] mem_q;

  // Storage: cleared by reset, otherwise one element updated per write strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[(int'(row_i) * N + int'(col_i)) * DW +: DW] <= data_i;
    end
  end

  assign mem_o = mem_q;

endmodule

// File: rtl/mm_sched.sv
// Sequencer for the NxN systolic multiplier: clear, skewed operand feed, drain, capture, done.
// Latency: start sampled at edge 0 -> done pulse at edge 3N+DRAIN_CYC+1; all outputs registered.
// No backpressure: start is a request honoured only in IDLE, never queued; writes only in IDLE.
module mm_sched
  import mm_pkg::*;
#(
  parameter int N         = MM_N,
  parameter int DW        = MM_DW,
  parameter int DRAIN_CYC = MM_DRAIN_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  output logic [N*DW-1:0]      a_out,
  output logic [N*DW-1:0]      b_out,
  output logic                 pe_clr,
  output logic                 cap_en,
  output logic                 busy,
  output logic                 done
);

  localparam int KW = cnt_width(N);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;

  logic [N*N*DW-1:0] a_mem, b_mem;
  logic              wr_ok;

  logic [N*DW-1:0] a_d, b_d;
  logic            pe_clr_d, cap_en_d, busy_d, done_d;
  int              d;

  // Writes land only while idle and in range; anything else is silently dropped.
  assign wr_ok = wr_en && (state_q == IDLE) && (int'(wr_row) < N) && (int'(wr_col) < N);

  mm_buf #(.N(N), .DW(DW)) u_buf_a (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_ok && !wr_sel),
    .row_i  (wr_row),
    .col_i  (wr_col),
    .data_i (wr_data),
    .mem_o  (a_mem)
  );

  mm_buf #(.N(N), .DW(DW)) u_buf_b (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_ok && wr_sel),
    .row_i  (wr_row),
    .col_i  (wr_col),
    .data_i (wr_data),
    .mem_o  (b_mem)
  );

  // Next-state logic; k restarts at 0 on every state entry.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          k_d     = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        k_d     = '0;
      end
      FEED: begin
        if (k_q == KW'(3 * N - 3)) begin
          state_d = (DRAIN_CYC == 0) ? CAPT : DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (k_q == KW'(DRAIN_CYC - 1)) begin
          state_d = CAPT;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      CAPT: begin
        state_d = DONE;
        k_d     = '0;
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Output next values from the current state: diagonal wavefront during FEED, zero elsewhere.
  always_comb begin
    a_d      = '0;
    b_d      = '0;
    d        = 0;
    pe_clr_d = (state_q == CLEAR);
    cap_en_d = (state_q == CAPT);
    done_d   = (state_q == DONE);
    busy_d   = (state_q != IDLE);
    if (state_q == FEED) begin
      for (int i = 0; i < N; i++) begin
        d = int'(k_q) - i;
        if (d >= 0 && d < N) begin
          a_d[i*DW +: DW] = a_mem[(i * N + d) * DW +: DW];
          b_d[i*DW +: DW] = b_mem[(d * N + i) * DW +: DW];
        end
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Output registers: every output lags the state that produced it by one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_out  <= '0;
      b_out  <= '0;
      pe_clr <= 1'b0;
      cap_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      a_out  <= a_d;
      b_out  <= b_d;
      pe_clr <= pe_clr_d;
      cap_en <= cap_en_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_mm_sched.sv
// Directed bench for mm_sched: reset, skewed feed, start/write blocking, range drop, mid-run reset.
// Edge numbering: edge 0 samples start; values checked #1 after each edge.
// Drives inputs right after the sampling point so each lands on the following edge.
module tb_mm_sched;

  localparam int N  = 5;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            wr_en;
  logic            wr_sel;
  logic [2:0]      wr_row;
  logic [2:0]      wr_col;
  logic [DW-1:0]   wr_data;
  logic [N*DW-1:0] a_out;
  logic [N*DW-1:0] b_out;
  logic            pe_clr;
  logic            cap_en;
  logic            busy;
  logic            done;

  int n_chk  = 0;
  int n_fail = 0;

  // Bench-side copy of the operand buffers.
  int ma [N][N];
  int mb [N][N];

  // Captured outputs for edges 0..19 of one run.
  logic [N*DW-1:0] cur_a [20];
  logic [N*DW-1:0] cur_b [20];
  logic [3:0]      cur_ctl [20]; // {pe_clr, cap_en, busy, done}

  mm_sched #(.N(N), .DW(DW), .DRAIN_CYC(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .a_out   (a_out),
    .b_out   (b_out),
    .pe_clr  (pe_clr),
    .cap_en  (cap_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic sel, input int row, input int col, input int data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = 3'(row);
    wr_col  = 3'(col);
    wr_data = 8'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  // Expected lane vector at feed step k from the bench's buffer copy.
  function automatic logic [N*DW-1:0] exp_lanes(input bit is_b, input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (k - i >= 0 && k - i < N) begin
        v[i*DW +: DW] = is_b ? 8'(mb[k-i][i]) : 8'(ma[i][k-i]);
      end
    end
    return v;
  endfunction

  // One run from IDLE: start at edge 0, optional start pulses s1/s2 and a write of
  // A[0][0]=FF at edge we, capturing outputs through edge 19.
  task automatic do_run(input int s1, input int s2, input int we);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      start = (e == s1 || e == s2);
      if (e == we) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'hFF;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cur_a[e]   = a_out;
      cur_b[e]   = b_out;
      cur_ctl[e] = {pe_clr, cap_en, busy, done};
    end
    start = 1'b0;
    wr_en = 1'b0;
  endtask

  // Whole-run schedule: clear @1, feed k=e-2 @2..14, capture @17, done @18, idle @19.
  task automatic check_run(input string name);
    logic [N*DW-1:0] ea, eb;
    logic [3:0]      ec;
    for (int e = 1; e <= 19; e++) begin
      ea = '0;
      eb = '0;
      if (e >= 2 && e <= 14) begin
        ea = exp_lanes(1'b0, e - 2);
        eb = exp_lanes(1'b1, e - 2);
      end
      ec = {(e == 1), (e == 17), (e <= 18), (e == 18)};
      chk($sformatf("%s_a_e%0d", name, e), 64'(cur_a[e]), 64'(ea));
      chk($sformatf("%s_b_e%0d", name, e), 64'(cur_b[e]), 64'(eb));
      chk($sformatf("%s_ctl_e%0d", name, e), 64'(cur_ctl[e]), 64'(ec));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end

    // Reset held with start asserted: everything stays zero.
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("rst_lanes_c%0d", c), 64'({a_out, b_out}), 64'(0));
      chk($sformatf("rst_ctl_c%0d", c), 64'({pe_clr, cap_en, busy, done}), 64'(0));
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_pe_clr", 64'(pe_clr), 64'(0));

    // Load A[i][j] = 5i+j+1, B = identity.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i * 5 + j + 1;
        mb[i][j] = (i == j) ? 1 : 0;
        wr(1'b0, i, j, ma[i][j]);
        wr(1'b1, i, j, mb[i][j]);
      end

    // Run 1. At k=4 (edge 6): a = {21,17,13,9,5}; b lane j = B[4-j][j] -> only lane 2.
    do_run(0, 0, 0);
    chk("r1_k4_a", 64'(cur_a[6]), 64'h15110d0905);
    chk("r1_k4_b", 64'(cur_b[6]), 64'h0000010000);
    chk("r1_cap17", 64'(cur_ctl[17][2]), 64'(1));
    chk("r1_done18", 64'(cur_ctl[18][0]), 64'(1));
    check_run("r1");

    // Run 2: start pulses at 5 and 18 plus a write at 8 are all ignored.
    do_run(5, 18, 8);
    check_run("r2");
    for (int e = 20; e <= 36; e++) begin
      tick();
      chk($sformatf("r2_idle_e%0d", e), 64'({busy, done}), 64'(0));
    end

    // Run 3: A[0][0] still 1.
    do_run(0, 0, 0);
    chk("r3_a00", 64'(cur_a[2][7:0]), 64'(1));
    check_run("r3");

    // Out-of-range row write is dropped; lanes unchanged.
    wr(1'b0, 5, 0, 8'hAA);
    do_run(0, 0, 0);
    check_run("r4");

    // Reset mid-FEED at k=6 (visible at edge 8), applied on edge 9.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 8; e++) tick();
    chk("mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b0;
    tick();
    chk("mid_rst_lanes", 64'({a_out, b_out}), 64'(0));
    chk("mid_rst_ctl", 64'({pe_clr, cap_en, busy, done}), 64'(0));
    rst = 1'b1;
    tick();
    chk("mid_rst_idle", 64'(busy), 64'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    do_run(0, 0, 0);
    check_run("r5");

    // Same-cycle write B[4][4]=7 and start: b lane 4 = 7 at k=8 (edge 10).
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = 3'd4; wr_col = 3'd4; wr_data = 8'd7;
    mb[4][4] = 7;
    do_run(0, 0, 0);
    chk("r6_b4_k8", 64'(cur_b[10][39:32]), 64'(7));
    check_run("r6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
